// File: rtl/aes_ks_pkg.sv
// Shared types, sizes and GF(2^8) helpers for the AES key-expansion engine.
package aes_ks_pkg;

  localparam int unsigned WORD      = 32;
  localparam int unsigned MAX_KEY_L = 256;
  localparam int unsigned RK_L      = 128;
  localparam int unsigned IDX_W     = 4;

  localparam logic [1:0] MODE_128  = 2'b00;
  localparam logic [1:0] MODE_192  = 2'b01;
  localparam logic [1:0] MODE_256  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef logic [WORD-1:0] word_t;

  typedef enum logic [1:0] {StIdle, StGen, StDrain} ks_state_e;

  function automatic logic [3:0] nk_of(input logic [1:0] mode);
    logic [3:0] nk;
    nk = 4'd4;
    case (mode)
      MODE_128:  nk = 4'd4;
      MODE_192:  nk = 4'd6;
      MODE_256:  nk = 4'd8;
      MODE_RSVD: nk = 4'd4;
    endcase
    return nk;
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    logic [3:0] nr;
    nr = 4'd10;
    case (mode)
      MODE_128:  nr = 4'd10;
      MODE_192:  nr = 4'd12;
      MODE_256:  nr = 4'd14;
      MODE_RSVD: nr = 4'd10;
    endcase
    return nr;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as inverse (x^254) followed by the affine map; avoids a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/round_key_sequencer_if.sv
// Round-key stream port: valid/ready handshake carrying a 128-bit key and its round number.
interface round_key_sequencer_if;
  import aes_ks_pkg::*;

  logic             rk_valid;
  logic             rk_ready;
  logic [RK_L-1:0]  rk_data;
  logic [IDX_W-1:0] rk_index;

  modport master (output rk_valid, output rk_data, output rk_index, input rk_ready);
  modport slave  (input rk_valid, input rk_data, input rk_index, output rk_ready);

endinterface

// File: rtl/sub_word_sync.sv
// Four parallel S-boxes with a registered output; the result holds until the next issue.
module sub_word_sync
  import aes_ks_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  in_valid,
  input  word_t in_word,
  output logic  out_valid,
  output word_t out_word
);

  word_t sub_d;
  word_t word_q;
  logic  valid_q;

  always_comb begin
    sub_d = {sbox(in_word[31:24]), sbox(in_word[23:16]), sbox(in_word[15:8]), sbox(in_word[7:0])};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) word_q <= sub_d;
    end
  end

  assign out_valid = valid_q;
  assign out_word  = word_q;

endmodule

// File: rtl/round_key_sequencer.sv
// Iterative AES-128/192/256 key expansion streaming round keys 0..Nr over a valid/ready port.
module round_key_sequencer
  import aes_ks_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            key_mode,
  input  logic [MAX_KEY_L-1:0]  key,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  round_key_sequencer_if.master rk_if
);

  ks_state_e        state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  word_t            win_q [8];
  word_t            win_d [8];
  logic [5:0]       i_q, i_d;
  logic [2:0]       pos_q, pos_d;
  logic [7:0]       rcon_q, rcon_d;
  word_t            acc_q [4];
  word_t            acc_d [4];
  logic [2:0]       acc_cnt_q, acc_cnt_d;
  logic             sub_hold_q, sub_hold_d;
  logic             rk_valid_q, rk_valid_d;
  logic [RK_L-1:0]  rk_data_q, rk_data_d;
  logic [IDX_W-1:0] rk_index_q, rk_index_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic       sub_in_valid, sub_out_valid;
  word_t      sub_in_word, sub_out_word;
  word_t      kw [8];
  logic [3:0] nk, nr, nk_new;
  logic [2:0] base_cnt;
  logic       out_free, sub_have, produce;
  word_t      w_old, new_w;

  sub_word_sync u_sub (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (sub_in_valid),
    .in_word   (sub_in_word),
    .out_valid (sub_out_valid),
    .out_word  (sub_out_word)
  );

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      kw[j] = key[MAX_KEY_L-1-WORD*j -: WORD];
    end
  end

  // win_q[0] is w[i-1]; win_q[Nk-1] is w[i-Nk].
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    win_d       = win_q;
    i_d         = i_q;
    pos_d       = pos_q;
    rcon_d      = rcon_q;
    acc_d       = acc_q;
    acc_cnt_d   = acc_cnt_q;
    rk_valid_d  = rk_valid_q;
    rk_data_d   = rk_data_q;
    rk_index_d  = rk_index_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    sub_in_valid = 1'b0;
    sub_in_word  = {win_q[0][23:0], win_q[0][31:24]};
    sub_have    = sub_out_valid | sub_hold_q;
    sub_hold_d  = sub_have;
    nk          = nk_of(mode_q);
    nr          = nr_of(mode_q);
    nk_new      = nk_of(key_mode);
    w_old       = win_q[3'(nk - 4'd1)];
    out_free    = !rk_valid_q || rk_if.rk_ready;
    base_cnt    = acc_cnt_q;
    produce     = 1'b0;
    new_w       = '0;

    if (rk_valid_q && rk_if.rk_ready) rk_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (key_mode == MODE_RSVD) begin
            err_d = 1'b1;
          end else begin
            mode_d = key_mode;
            for (int k = 0; k < 8; k++) begin
              win_d[k] = (4'(k) < nk_new) ? kw[3'(nk_new - 4'(k) - 4'd1)] : '0;
            end
            for (int j = 0; j < 4; j++) begin
              acc_d[j] = kw[4+j];
            end
            acc_cnt_d  = 3'(nk_new - 4'd4);
            rcon_d     = RCON_INIT;
            i_d        = 6'(nk_new);
            pos_d      = '0;
            sub_hold_d = 1'b0;
            rk_valid_d = 1'b1;
            rk_data_d  = key[MAX_KEY_L-1 -: RK_L];
            rk_index_d = '0;
            state_d    = StGen;
          end
        end
      end
      StGen, StDrain: begin
        if (acc_cnt_q == 3'd4 && out_free) begin
          rk_valid_d = 1'b1;
          rk_data_d  = {acc_q[0], acc_q[1], acc_q[2], acc_q[3]};
          rk_index_d = rk_index_q + 1'b1;
          acc_cnt_d  = '0;
          base_cnt   = '0;
        end

        if (state_q == StGen && base_cnt != 3'd4) begin
          if (pos_q == 3'd0) begin
            if (sub_have) begin
              new_w   = w_old ^ sub_out_word ^ {rcon_q, 24'h0};
              rcon_d  = xtime(rcon_q);
              produce = 1'b1;
            end else begin
              sub_in_valid = 1'b1;
            end
          end else if (nk == 4'd8 && pos_q == 3'd4) begin
            if (sub_have) begin
              new_w   = w_old ^ sub_out_word;
              produce = 1'b1;
            end
          end else begin
            new_w   = w_old ^ win_q[0];
            produce = 1'b1;
            // Prefetch SubWord for the following i%8==4 word so it costs one cycle.
            if (nk == 4'd8 && pos_q == 3'd3) begin
              sub_in_valid = 1'b1;
              sub_in_word  = new_w;
            end
          end

          if (produce) begin
            sub_hold_d = 1'b0;
            win_d[0]   = new_w;
            for (int k = 1; k < 8; k++) begin
              win_d[k] = win_q[k-1];
            end
            i_d   = i_q + 6'd1;
            pos_d = (pos_q == 3'(nk - 4'd1)) ? 3'd0 : pos_q + 3'd1;
            if (base_cnt == 3'd3 && out_free) begin
              rk_valid_d = 1'b1;
              rk_data_d  = {acc_q[0], acc_q[1], acc_q[2], new_w};
              rk_index_d = rk_index_q + 1'b1;
              acc_cnt_d  = '0;
            end else begin
              acc_d[base_cnt[1:0]] = new_w;
              acc_cnt_d            = base_cnt + 3'd1;
            end
            if (i_q == {nr, 2'b11}) state_d = StDrain;
          end
        end

        if (state_q == StDrain && rk_valid_q && rk_if.rk_ready && rk_index_q == nr &&
            acc_cnt_q == 3'd0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      mode_q     <= MODE_128;
      win_q      <= '{default: '0};
      i_q        <= '0;
      pos_q      <= '0;
      rcon_q     <= RCON_INIT;
      acc_q      <= '{default: '0};
      acc_cnt_q  <= '0;
      sub_hold_q <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_index_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      win_q      <= win_d;
      i_q        <= i_d;
      pos_q      <= pos_d;
      rcon_q     <= rcon_d;
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      sub_hold_q <= sub_hold_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q  <= rk_data_d;
      rk_index_q <= rk_index_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign err            = err_q;
  assign rk_if.rk_valid = rk_valid_q;
  assign rk_if.rk_data  = rk_data_q;
  assign rk_if.rk_index = rk_index_q;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed FIPS-197 key-schedule vectors, back-pressure, reserved mode and mid-job reset.
module tb_round_key_sequencer;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   key_mode;
  logic [255:0] key;
  logic         busy;
  logic         done;
  logic         err;

  int n_checks;
  int n_fail;

  round_key_sequencer_if rk_if ();

  round_key_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_mode (key_mode),
    .key      (key),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rk_if    (rk_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] A1_KEY = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
  localparam logic [255:0] A2_KEY = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b,
                                     64'h0};
  localparam logic [255:0] A3_KEY = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  localparam logic [127:0] A1_TAB [11] = '{
    128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
    128'ha0fafe17_88542cb1_23a33939_2a6c7605,
    128'hf2c295f2_7a96b943_5935807a_7359f67f,
    128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
    128'hef44a541_a8525b7f_b671253b_db0bad00,
    128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
    128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
    128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
    128'head27321_b58dbad2_312bf560_7f8d292f,
    128'hac7766f3_19fadc21_28d12941_575c006e,
    128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
  };

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_busy"}, 256'(busy), 256'(0));
    check_eq({tag, "_valid"}, 256'(rk_if.rk_valid), 256'(0));
    check_eq({tag, "_done"}, 256'(done), 256'(0));
    check_eq({tag, "_err"}, 256'(err), 256'(0));
    check_eq({tag, "_data"}, 256'(rk_if.rk_data), 256'(0));
    check_eq({tag, "_index"}, 256'(rk_if.rk_index), 256'(0));
  endtask

  // Called at a negedge with the engine idle; returns at the negedge where done is seen.
  task automatic run_job(input string name, input logic [1:0] mode, input logic [255:0] k,
                         input int unsigned rdy_pct, input int nr_exp,
                         input logic [127:0] exp_r0, input logic [127:0] exp_r1,
                         input logic [127:0] exp_last, input bit use_a1, input int lat_exp);
    int           cyc;
    int           nxt;
    bit           seen;
    bit           stall;
    logic [127:0] pd;
    logic [3:0]   pi;
    start    = 1'b1;
    key_mode = mode;
    key      = k;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    nxt   = 0;
    seen  = 1'b0;
    stall = 1'b0;
    pd    = '0;
    pi    = '0;
    check_eq({name, "_busy_start"}, 256'(busy), 256'(1));
    check_eq({name, "_valid_start"}, 256'(rk_if.rk_valid), 256'(1));
    check_eq({name, "_done_start"}, 256'(done), 256'(0));
    while (!seen && cyc < 400) begin
      if (done) begin
        seen = 1'b1;
        if (lat_exp > 0) check_eq({name, "_latency"}, 256'(cyc - 1), 256'(lat_exp));
        check_eq({name, "_busy_done"}, 256'(busy), 256'(0));
        check_eq({name, "_valid_done"}, 256'(rk_if.rk_valid), 256'(0));
        check_eq({name, "_transfers"}, 256'(nxt), 256'(nr_exp + 1));
      end else begin
        if (stall) begin
          check_eq({name, "_hold_data"}, 256'(rk_if.rk_data), 256'(pd));
          check_eq({name, "_hold_index"}, 256'(rk_if.rk_index), 256'(pi));
        end
        rk_if.rk_ready = ($urandom_range(0, 99) < rdy_pct);
        if (rk_if.rk_valid) begin
          if (rk_if.rk_ready) begin
            check_eq({name, "_index"}, 256'(rk_if.rk_index), 256'(nxt));
            if (use_a1) begin
              if (nxt <= 10) check_eq({name, "_rk"}, 256'(rk_if.rk_data), 256'(A1_TAB[nxt]));
            end else begin
              if (nxt == 0) check_eq({name, "_rk0"}, 256'(rk_if.rk_data), 256'(exp_r0));
              if (nxt == 1 && exp_r1 != '0)
                check_eq({name, "_rk1"}, 256'(rk_if.rk_data), 256'(exp_r1));
              if (nxt == nr_exp) check_eq({name, "_rklast"}, 256'(rk_if.rk_data), 256'(exp_last));
            end
            nxt++;
          end
          stall = !rk_if.rk_ready;
          pd    = rk_if.rk_data;
          pi    = rk_if.rk_index;
        end else begin
          stall = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check_eq({name, "_done_seen"}, 256'(seen), 256'(1));
  endtask

  initial begin
    bit found;
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b0;
    start          = 1'b0;
    key_mode       = 2'b00;
    key            = '0;
    rk_if.rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back 128 -> 192 -> 256 with full throughput.
    run_job("a1", 2'b00, A1_KEY, 100, 10, '0, '0, '0, 1'b1, 51);
    run_job("a2", 2'b01, A2_KEY, 100, 12, A2_KEY[255:128], '0,
            128'he98ba06f_448c773c_8ecc7204_01002202, 1'b0, 55);
    run_job("a3", 2'b10, A3_KEY, 100, 14, A3_KEY[255:128], A3_KEY[127:0],
            128'hfe4890d1_e6188d0b_046df344_706c631e, 1'b0, 60);

    run_job("a1_bp", 2'b00, A1_KEY, 30, 10, '0, '0, '0, 1'b1, 0);

    // Reserved mode: one-cycle err, no job.
    @(negedge clk);
    start    = 1'b1;
    key_mode = 2'b11;
    key      = A1_KEY;
    @(negedge clk);
    start = 1'b0;
    check_eq("rsvd_err", 256'(err), 256'(1));
    check_eq("rsvd_busy", 256'(busy), 256'(0));
    check_eq("rsvd_valid", 256'(rk_if.rk_valid), 256'(0));
    @(negedge clk);
    check_eq("rsvd_err_clear", 256'(err), 256'(0));
    check_eq("rsvd_busy_after", 256'(busy), 256'(0));
    run_job("a2_after_rsvd", 2'b01, A2_KEY, 100, 12, A2_KEY[255:128], '0,
            128'he98ba06f_448c773c_8ecc7204_01002202, 1'b0, 55);

    // Mid-job reset at round 5 of a 256 job.
    @(negedge clk);
    start          = 1'b1;
    key_mode       = 2'b10;
    key            = A3_KEY;
    rk_if.rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (rk_if.rk_valid && rk_if.rk_index == 4'd5) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("reach_idx5", 256'(found), 256'(1));
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("midreset");
    reset = 1'b1;
    @(negedge clk);
    run_job("a1_after_reset", 2'b00, A1_KEY, 100, 10, '0, '0, '0, 1'b1, 51);
    @(negedge clk);
    check_eq("done_one_cycle", 256'(done), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
